// File: rtl/vec_acc_requant.sv
// vec_acc_requant: accumulates grouped partial dot products with bias, then round-shifts, ReLUs and saturates into a valid/ready output register
module vec_acc_requant #(
  parameter int C     = 16,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int W_Y   = W_X + W_K + $clog2(C),
  parameter int W_ACC = 32,
  parameter int W_OUT = 8,
  parameter int W_SH  = 5,
  parameter int W_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [W_Y-1:0]   s_data,
  input  logic                    s_last,
  input  logic signed [W_ACC-1:0] bias,
  input  logic [W_SH-1:0]         shift,
  input  logic                    relu,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [W_OUT-1:0] m_data,
  output logic                    m_sat,
  output logic [W_CNT-1:0]        m_beats
);
  localparam logic signed [W_ACC:0] MAXV = (W_ACC+1)'((1 << (W_OUT-1)) - 1);
  localparam logic signed [W_ACC:0] MINV = ~MAXV;
  logic signed [W_ACC-1:0] acc, sum;
  logic signed [W_ACC:0] sum_x, half, r_sh, r;
  logic [W_CNT-1:0] beat_cnt, cnt;
  logic first, accept, hi, lo;
  logic signed [W_OUT-1:0] q;
  assign s_ready = !m_valid || m_ready;
  assign accept = s_valid && s_ready;
  assign sum = (first ? bias : acc) + W_ACC'(s_data);
  assign cnt = (first ? '0 : beat_cnt) + W_CNT'(1);
  // one extra bit so adding the rounding half cannot overflow before the shift
  assign sum_x = (W_ACC+1)'(sum);
  assign half = (W_ACC+1)'(1) << (shift - W_SH'(1));
  assign r_sh = (shift == '0) ? sum_x : (sum_x + half) >>> shift;
  assign r = (relu && r_sh < 0) ? '0 : r_sh;
  assign hi = r > MAXV;
  assign lo = r < MINV;
  assign q = hi ? MAXV[W_OUT-1:0] : lo ? MINV[W_OUT-1:0] : r[W_OUT-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      first <= 1'b1;
      beat_cnt <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sat <= 1'b0;
      m_beats <= '0;
    end else begin
      if (accept && s_last) begin
        acc <= '0;
        first <= 1'b1;
        beat_cnt <= '0;
        m_valid <= 1'b1;
        m_data <= q;
        m_sat <= hi || lo;
        m_beats <= cnt;
      end else begin
        if (accept) begin
          acc <= sum;
          first <= 1'b0;
          beat_cnt <= cnt;
        end
        if (m_valid && m_ready) m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vec_acc_requant.sv
// tb_vec_acc_requant: directed plan cases plus randomized groups scored against an arithmetic model
module tb_vec_acc_requant;
  localparam int W_Y = 20, W_ACC = 32, W_OUT = 8, W_SH = 5, W_CNT = 8;
  logic clk = 1'b0;
  logic rst, s_valid, s_last, relu, m_ready;
  logic s_ready, m_valid, m_sat;
  logic signed [W_Y-1:0] s_data;
  logic signed [W_ACC-1:0] bias;
  logic [W_SH-1:0] shift;
  logic signed [W_OUT-1:0] m_data;
  logic [W_CNT-1:0] m_beats;
  int n_pass = 0, n_chk = 0;
  bit rnd_en = 0;
  typedef struct {longint d; bit sat; longint beats;} res_t;
  res_t q[$];
  longint macc = 0, mcnt = 0;
  bit mfirst = 1;

  vec_acc_requant dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .bias(bias), .shift(shift), .relu(relu), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat), .m_beats(m_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint wrap(input longint x);
    logic signed [W_ACC-1:0] t;
    t = x[W_ACC-1:0];
    return t;
  endfunction

  function automatic res_t requant(input longint sum, input int sh, input bit rl, input longint beats);
    longint r, dv;
    res_t o;
    r = sum;
    if (sh != 0) begin
      dv = longint'(1) << sh;
      r = sum + dv / 2;
      r = (r >= 0) ? r / dv : -((-r + dv - 1) / dv);
    end
    if (rl && r < 0) r = 0;
    o.sat = (r > 127) || (r < -128);
    o.d = (r > 127) ? 127 : (r < -128) ? -128 : r;
    o.beats = beats;
    return o;
  endfunction

  task automatic model_reset();
    macc = 0;
    mcnt = 0;
    mfirst = 1;
    q.delete();
  endtask

  // called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic beat(input longint d, input bit last, input longint b, input int sh, input bit rl);
    bit ok = 0;
    longint s, c;
    s_valid = 1;
    s_data = W_Y'(d);
    s_last = last;
    bias = W_ACC'(b);
    shift = W_SH'(sh);
    relu = rl;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
    end
    s_valid = 0;
    if (!ok) chk("handshake_timeout", 0, 1);
    else begin
      s = wrap((mfirst ? b : macc) + d);
      c = ((mfirst ? 0 : mcnt) + 1) % 256;
      if (last) begin
        q.push_back(requant(s, sh, rl, c));
        macc = 0;
        mcnt = 0;
        mfirst = 1;
      end else begin
        macc = s;
        mcnt = c;
        mfirst = 0;
      end
    end
  endtask

  task automatic check_res(input string tag);
    res_t e;
    if (q.size() == 0) begin
      chk({tag, "_expected_missing"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, m_data, e.d);
    chk({tag, "_sat"}, m_sat, e.sat);
    chk({tag, "_beats"}, m_beats, e.beats);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rnd_en) begin
      chk("s_ready_rule", s_ready, !m_valid || m_ready);
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_result", 0, 1);
        else begin
          res_t e;
          e = q.pop_front();
          chk("rnd_data", m_data, e.d);
          chk("rnd_sat", m_sat, e.sat);
          chk("rnd_beats", m_beats, e.beats);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      m_ready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    rst = 1; s_valid = 0; s_last = 0; s_data = '0; bias = '0; shift = '0; relu = 0; m_ready = 1;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_m_beats", m_beats, 0);
    chk("rst_s_ready", s_ready, 1);
    rst = 0;
    beat(100, 1, 0, 0, 0);
    chk("single_const", m_data, 100);
    check_res("single");
    beat(1000, 0, 10, 5, 0); beat(2000, 0, 0, 5, 0); beat(-500, 1, 0, 5, 0);
    chk("three_sh5_const", m_data, 78);
    check_res("three_sh5");
    beat(1000, 0, 10, 4, 0); beat(2000, 0, 0, 4, 0); beat(-500, 1, 0, 4, 0);
    chk("three_sh4_const", m_data, 127);
    check_res("three_sh4");
    beat(-24, 1, 0, 4, 0);
    chk("round_neg_const", m_data, -1);
    check_res("round_neg");
    beat(-24, 1, 0, 4, 1);
    chk("relu_const", m_data, 0);
    check_res("relu");
    beat(-262144, 1, 0, 0, 0);
    chk("neg_sat_const", m_data, -128);
    check_res("neg_sat");
    beat(0, 1, 64'h7FF00000, 24, 0);
    check_res("wide_round");
    beat(1, 1, 64'h7FFFFFFF, 0, 0);
    check_res("acc_wrap");
    for (int i = 0; i < 300; i++) beat(i % 3 - 1, i == 299, 5, 2, 0);
    chk("cnt_wrap_const", m_beats, 44);
    check_res("cnt_wrap");
    tick();
    m_ready = 0;
    beat(9, 1, 0, 0, 0);
    check_res("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 9);
      chk("bp_m_beats", m_beats, 1);
    end
    tick();
    chk("bp_still_valid", m_valid, 1);
    m_ready = 1;
    beat(7, 1, 0, 0, 0);
    chk("b2b_const", m_data, 7);
    check_res("b2b");
    beat(50, 0, 0, 0, 0);
    beat(60, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_during", m_valid, 0);
    tick();
    rst = 0;
    model_reset();
    chk("rst_mid_after", m_valid, 0);
    tick();
    chk("rst_mid_after2", m_valid, 0);
    beat(5, 1, 3, 0, 0);
    chk("rst_mid_const", m_data, 8);
    check_res("rst_mid");
    tick(); tick(); tick();
    rnd_en = 1;
    for (int g = 0; g < 60; g++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        longint d, b;
        d = longint'($urandom_range(0, (1 << W_Y) - 1)) - (1 << (W_Y - 1));
        b = longint'(int'($urandom)) >>> $urandom_range(6, 24);
        beat(d, i == len - 1, b, $urandom_range(0, 12), $urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    for (int k = 0; k < 1000 && q.size() != 0; k++) tick();
    chk("drain_empty", q.size(), 0);
    rnd_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
